div_seq: RTL and testbench

Iterative signed integer divider for the processor's multdiv path. It accepts a dividend and divisor on a one-cycle start pulse and runs a radix-2 restoring division on the operand magnitudes, one quotient bit per cycle. It then applies two's-complement sign correction and presents the quotient with a single-cycle ready pulse. The subtract step forms R + ~D + 1 using the datapath's bitwise-invert. The block sits beside the ALU and is stalled on by the pipeline until ready is seen.

---
 rtl/div_seq.sv | 121 ++++++++++++
 tb/tb_div_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: iterative signed radix-2 restoring divider for the multdiv path.
// Ports: clock, reset_n (async low), ctrl_div start pulse, data_operandA
//   dividend, data_operandB divisor; data_result quotient (toward zero),
//   data_exception (div-by-zero/overflow), data_resultRDY one-cycle valid.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg;
  logic             exc;
  logic [WIDTH-1:0] exc_val;

  logic             zero_in;
  logic             ovf_in;
  logic             exc_in;
  logic [WIDTH-1:0] rsh;
  logic [WIDTH:0]   diff;

  // Magnitude as unsigned WIDTH bits: -2^(WIDTH-1) maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  assign zero_in = (data_operandB == '0);
  assign ovf_in  = (data_operandA == MIN) && (data_operandB == '1);
  assign exc_in  = zero_in | ovf_in;

  // Shifted partial remainder and trial subtract R + ~D + 1.
  // The extra top bit is the borrow: set means R < D.
  assign rsh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign diff = {1'b0, rsh} + {1'b1, ~dvs} + (WIDTH+1)'(1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (ctrl_div) state_nxt = exc_in ? DONE : RUN;
      RUN: begin
        if (ctrl_div) state_nxt = exc_in ? DONE : RUN;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (ctrl_div) state_nxt = exc_in ? DONE : RUN;
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      neg            <= 1'b0;
      exc            <= 1'b0;
      exc_val        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_div) begin
        // Start from any state; an in-flight operation is dropped.
        cnt     <= '0;
        rem     <= '0;
        quo     <= mag(data_operandA);
        dvs     <= mag(data_operandB);
        neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        exc     <= exc_in;
        exc_val <= ovf_in ? MIN : '0;
      end else begin
        unique case (state)
          RUN: begin
            rem <= diff[WIDTH] ? rsh : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + CW'(1);
          end
          DONE: begin
            if (exc) data_result <= exc_val;
            else data_result <= neg ? (~quo + WIDTH'(1)) : quo;
            data_exception <= exc;
            data_resultRDY <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq results, latency and control.
// Drives on negedge, samples 1 time unit after posedge.
module tb_div_seq;

  logic        clock;
  logic        reset_n;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_div      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_div      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
  endtask

  // Start an op, measure cycles to RDY, check result and pulse width.
  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input int lat_exp,
                        input logic [31:0] q_exp, input logic e_exp);
    int lat;
    pulse(a, b);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = n;
        break;
      end
    end
    chk({tag, " lat"}, 32'(lat), 32'(lat_exp));
    chk({tag, " q"}, data_result, q_exp);
    chk({tag, " exc"}, 32'(data_exception), 32'(e_exp));
    @(posedge clock);
    #1;
    chk({tag, " rdy1"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int hits;
    reset_n       = 1'b1;
    ctrl_div      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("rst q", data_result, 32'd0);
    chk("rst exc", 32'(data_exception), 32'd0);
    chk("rst rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("100/7", 32'd100, 32'd7, 33, 32'h0000_000E, 1'b0);
    run_op("-100/7", -32'sd100, 32'd7, 33, 32'hFFFF_FFF2, 1'b0);
    run_op("100/-7", 32'd100, -32'sd7, 33, 32'hFFFF_FFF2, 1'b0);
    run_op("-100/-7", -32'sd100, -32'sd7, 33, 32'h0000_000E, 1'b0);
    run_op("0/5", 32'd0, 32'd5, 33, 32'd0, 1'b0);
    run_op("5/7", 32'd5, 32'd7, 33, 32'd0, 1'b0);
    run_op("div0", 32'd1234, 32'd0, 1, 32'd0, 1'b1);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1);
    run_op("min/2", 32'h8000_0000, 32'd2, 33, 32'hC000_0000, 1'b0);
    run_op("max/1", 32'h7FFF_FFFF, 32'd1, 33, 32'h7FFF_FFFF, 1'b0);
    run_op("min/min", 32'h8000_0000, 32'h8000_0000, 33, 32'd1, 1'b0);

    // Restart mid-RUN: the first op must never pulse.
    pulse(32'd100, 32'd7);
    hits = 0;
    for (int n = 1; n < 10; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) hits++;
    end
    chk("abort rdy", 32'(hits), 32'd0);
    run_op("81/9", 32'd81, 32'd9, 33, 32'd9, 1'b0);

    // Async reset mid-RUN, between edges.
    pulse(32'd100, 32'd7);
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst q", data_result, 32'd0);
    chk("mrst exc", 32'(data_exception), 32'd0);
    chk("mrst rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) hits++;
    end
    chk("post rst rdy", 32'(hits), 32'd0);
    run_op("6/3", 32'd6, 32'd3, 33, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
